// File: rtl/maxpool2d_unit.sv
// Streaming 2x2 stride-2 signed max-pool over raster-ordered pixels of col lanes.
// One pooled pixel is emitted (registered) per completed window.

module maxpool2d_lane #(
    parameter int psum_bw = 16
) (
    input  logic [psum_bw-1:0] hold,
    input  logic [psum_bw-1:0] in_px,
    input  logic [psum_bw-1:0] row_px,
    output logic [psum_bw-1:0] pm,
    output logic [psum_bw-1:0] win
);
    assign pm  = ($signed(hold) > $signed(in_px)) ? hold : in_px;
    assign win = ($signed(row_px) > $signed(pm)) ? row_px : pm;
endmodule

module maxpool2d_unit #(
    parameter  int col     = 8,
    parameter  int psum_bw = 16,
    parameter  int ofmap_w = 4,
    parameter  int ofmap_h = 4,
    localparam int NPOOL   = (ofmap_w / 2) * (ofmap_h / 2),
    localparam int IDX_W   = (NPOOL > 1) ? $clog2(NPOOL) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [col*psum_bw-1:0]   in_data,
    output logic                     out_valid,
    output logic [col*psum_bw-1:0]   out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     frame_done
);
    localparam int HW = ofmap_w / 2;
    localparam int XW = $clog2(ofmap_w);
    localparam int YW = $clog2(ofmap_h);
    localparam int RW = (HW > 1) ? $clog2(HW) : 1;

    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          x_last, y_last;
    logic [RW-1:0] bx;
    logic [IDX_W-1:0] idx_next;

    logic [col-1:0][psum_bw-1:0] in_lanes, hold, row_rd, pm, win;
    // Holds the horizontal pair maxima of the even row of each window pair.
    logic [col-1:0][psum_bw-1:0] rowbuf [HW];

    assign in_lanes = in_data;
    assign x_last   = (x == XW'(ofmap_w - 1));
    assign y_last   = (y == YW'(ofmap_h - 1));
    assign bx       = RW'(x >> 1);
    assign row_rd   = rowbuf[bx];
    assign idx_next = IDX_W'(y >> 1) * IDX_W'(HW) + IDX_W'(x >> 1);

    for (genvar c = 0; c < col; c++) begin : g_lane
        maxpool2d_lane #(.psum_bw(psum_bw)) u_lane (
            .hold   (hold[c]),
            .in_px  (in_lanes[c]),
            .row_px (row_rd[c]),
            .pm     (pm[c]),
            .win    (win[c])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            hold       <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_data   <= '0;
            out_idx    <= '0;
        end else begin
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (in_valid) begin
                if (!x[0]) begin
                    hold <= in_lanes;
                end else if (y[0]) begin
                    out_valid  <= 1'b1;
                    out_data   <= win;
                    out_idx    <= idx_next;
                    frame_done <= x_last && y_last;
                end
                x <= x_last ? '0 : x + 1'b1;
                if (x_last)
                    y <= y_last ? '0 : y + 1'b1;
            end
        end
    end

    // Row buffer needs no reset: every entry is written on an even row before it is read.
    always_ff @(posedge clk) begin
        if (!reset && in_valid && x[0] && !y[0])
            rowbuf[bx] <= pm;
    end
endmodule

// File: doc/maxpool2d_unit.md
# maxpool2d_unit

Streaming 2x2, stride-2 max-pool stage placed directly downstream of the SFP output of `core`. It consumes one output pixel per valid cycle, carrying all `col` output channels, in raster (row-major, oc_nij) order. It emits one pooled pixel per 2x2 window. Pooled pixels are written back to PMEM or compared by the bench, so the Alpha4 layer produces a 2x2 pooled map from the 4x4 conv output.

## Interface
- `col`, 8, output channels per pixel (lanes)
- `psum_bw`, 16, lane width; two's-complement signed
- `ofmap_w`, 4, conv output map width in pixels; even, >= 2
- `ofmap_h`, 4, conv output map height in pixels; even, >= 2
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  `in_data` holds a valid pixel this cycle
- `in_data`  in  col*psum_bw  pixel; lane c = bits [c*psum_bw +: psum_bw]
- `out_valid`  out  1  `out_data` and `out_idx` valid this cycle (one-cycle pulse per pooled pixel)
- `out_data`  out  col*psum_bw  pooled pixel, same lane packing as `in_data`
- `out_idx`  out  clog2((ofmap_w/2)*(ofmap_h/2))  raster index of the pooled pixel, range 0..(ofmap_w/2)*(ofmap_h/2)-1
- `frame_done`  out  1  one-cycle pulse coincident with the last `out_valid` of a frame

## Operation
- Counters: `x` runs 0..ofmap_w-1 and `y` runs 0..ofmap_h-1. Both advance only on cycles with `in_valid`=1. `x` wraps to 0 and increments `y`. At x=ofmap_w-1 and y=ofmap_h-1, both wrap to 0, so the next frame starts with no idle cycle.
- Pair register: on valid input with even `x`, latch `in_data` into `hold`.
- Pair max: on valid input with odd `x`, pm = lane-wise signed max(hold, in_data).
- Row buffer: ofmap_w/2 entries of col*psum_bw bits. On even `y`, write pm to entry x/2.
- Output: on odd `y`, register lane-wise signed max(rowbuf[x/2], pm) into `out_data`. Assert `out_valid` and set `out_idx` = (y/2)*(ofmap_w/2) + x/2.
- Max rules:
  - Per lane and independent. Signed comparison; no saturation or truncation.
  - Ties select either operand, since the values are identical.
- `frame_done` asserts with the output for x=ofmap_w-1, y=ofmap_h-1.
- No back-pressure. The downstream consumer must accept every `out_valid` pulse.
- Gaps in `in_valid`: all state holds, and an idle cycle has no effect on results.

## Timing
- Reset values:
  - `out_valid`=0, `frame_done`=0, `out_data`=0, `out_idx`=0.
  - `x`=0, `y`=0, `hold`=0.
  - Row buffer contents need not be cleared; they are always written before being read.
- Latency: `out_valid` is high in the cycle after the rising edge that samples the odd-x, odd-y input pixel. That is one cycle of latency, with registered outputs.
- Throughput: one input per cycle sustained. One output per four inputs, and outputs are never back-to-back.
- `out_valid` and `frame_done` are single-cycle. Each deasserts on the next edge unless a new window completes.
- Reset during a frame:
  - Any partial window or row is discarded; counters return to 0.
  - No output is produced from pre-reset data.
  - An input presented in the same cycle as `reset`=1 is ignored.
- Between frames: with `in_valid` held high across the boundary, pixel 0 of frame N+1 is sampled on the edge immediately after the last pixel of frame N.

## Test plan
- Ascending frame: all lanes of pixel p = p (p=0..15), continuous valid.
  - Outputs 5, 7, 13, 15 in all lanes, with `out_idx` 0..3.
  - `frame_done` coincides with idx 3.
- Negative values: all lanes = p-16.
  - Outputs 0xFFF5, 0xFFF7, 0xFFFD, 0xFFFF (-11, -9, -3, -1).
  - This checks the comparison is signed and not unsigned.
- Lane independence: lane c of pixel p = (c odd) ? -p : p.
  - Even lanes give 5, 7, 13, 15.
  - Odd lanes give 0, -2, -8, -10.
- Bubbles: same stimulus as the ascending frame, with `in_valid` low for a pseudo-random 0-3 cycles between pixels.
  - Results are identical to the ascending frame.
  - Each `out_valid` comes exactly one cycle after its completing input.
- Reset mid-frame: pulse `reset` after pixel 9, then send a full ascending frame.
  - No `out_valid` appears before the new frame completes its first window.
  - Outputs are then 5, 7, 13, 15.
- Back-to-back frames: two frames streamed with no gap, the second being the first with +100 added.
  - Outputs 5, 7, 13, 15, 105, 107, 113, 115.
  - `frame_done` pulses twice.
